ray_result_writer: RTL and testbench
====================================

Name: ray_result_writer

Overview:
- Sits directly downstream of ray_unit and consumes its per-pixel result (hcount_out, vcount_out, color_out, ready_out).
- Range-checks each result and converts (h,v) to a linear frame-buffer address.
- Buffers results in a small FIFO and drives a BRAM write port that the display read side can stall.
- Counts committed pixels and pulses frame_done_out once a full frame has been written.

Parameters:
- DISPLAY_WIDTH, 400, pixels per row
- DISPLAY_HEIGHT, 300, rows per frame
- H_BITS, 9, hcount width
- V_BITS, 9, vcount width
- FIFO_DEPTH, 8, FIFO entries; must be a power of two, at least 2
- ADDR_BITS, 17, frame-buffer address width; must satisfy 2^ADDR_BITS >= DISPLAY_WIDTH*DISPLAY_HEIGHT

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- clear_in  input  1  synchronous flush of FIFO and pixel counter (new frame or fractal change)
- result_valid_in  input  1  ray_unit ready_out; result fields valid this cycle
- hcount_in  input  H_BITS  pixel column
- vcount_in  input  V_BITS  pixel row
- color_in  input  4  pixel colour
- space_out  output  1  FIFO not full; upstream may present a result
- wr_ready_in  input  1  frame-buffer port free this cycle
- we_out  output  1  BRAM write enable, one cycle per pixel
- addr_out  output  ADDR_BITS  BRAM write address
- data_out  output  4  BRAM write data
- frame_done_out  output  1  one-cycle pulse after the last pixel of a frame is written
- overflow_out  output  1  sticky; a valid result arrived while the FIFO was full

Behaviour:
- Reset (async): all outputs 0 except space_out=1. FIFO is empty, pixel counter is 0, overflow_out is 0.
- Accept rule: a result is pushed when result_valid_in=1, count<FIFO_DEPTH, and both coordinates are in range.
  - The full check uses the count at the start of the cycle. A pop in the same cycle does not free a slot for that cycle's push.
- Out of range (hcount_in>=DISPLAY_WIDTH or vcount_in>=DISPLAY_HEIGHT): the result is silently dropped. It is not pushed, not counted, and does not set overflow.
- Full: a valid result is dropped and overflow_out is set to 1. overflow_out clears only on rst_in or clear_in.
- Address: addr = vcount_in*DISPLAY_WIDTH + hcount_in, computed before the push at full ADDR_BITS width. The FIFO entry is {addr, color}.
- Drain: when the FIFO is non-empty and wr_ready_in=1, the head entry is popped and loaded into the output registers. we_out=1 in the next cycle with that addr/data. Otherwise we_out=0, and addr_out/data_out hold their last values.
- Latency: a result accepted in cycle N with the FIFO empty and wr_ready_in high gives we_out=1 in cycle N+2. Sustained throughput is 1 pixel/cycle.
- space_out = (count<FIFO_DEPTH), combinational from registered count.
- Pixel counter increments on every we_out=1 cycle.
  - When the increment reaches DISPLAY_WIDTH*DISPLAY_HEIGHT, the counter wraps to 0 and frame_done_out=1 for exactly the following cycle.
  - Duplicate coordinates are counted each time; no deduplication.
- clear_in=1 (synchronous):
  - FIFO is emptied, counter set to 0, overflow cleared.
  - A push and a pop requested in the same cycle are both suppressed.
  - we_out is 0 next cycle; frame_done_out is 0 next cycle even if a wrap was due.
  - clear_in has priority over all other activity.
- rst_in mid-operation: immediate return to reset state. In-flight entries are lost.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: RAY_WRITER_STATS_EN.
- Defined: adds outputs drop_count_out[15:0] and oob_count_out[15:0].
  - drop_count_out counts results dropped because the FIFO was full.
  - oob_count_out counts out-of-range results.
  - Both saturate at 16'hFFFF, reset to 0 on rst_in, and clear on clear_in.
- Undefined: neither port nor its counters exist. All other behaviour is identical.

Test Plan:
- Single result h=150, v=150, color=4'hA at cycle N, wr_ready_in=1 -> we_out=1 at N+2, addr_out=60150, data_out=4'hA, exactly one write.
- Results h=400,v=0 and h=0,v=300 -> no push, no we_out, overflow_out=0; with RAY_WRITER_STATS_EN, oob_count_out=2.
- wr_ready_in=0, 10 consecutive valid results (FIFO_DEPTH=8) -> space_out=0 after the 8th push, overflow_out=1. Raising wr_ready_in then yields exactly 8 writes in push order and no more; with RAY_WRITER_STATS_EN, drop_count_out=2.
- Stream all 120000 pixels in raster order, wr_ready_in=1 -> frame_done_out pulses once, one cycle after the last we_out. The counter restarts, and a further 120000 pixels produce a second pulse.
- clear_in asserted with 5 entries queued and a valid result present -> next cycle we_out=0, space_out=1, overflow_out=0, and no writes from the flushed entries.
- rst_in asserted asynchronously mid-stream, between clock edges -> outputs go to reset values before the next edge; after release, the first new result writes normally with latency 2.

Source files
------------

// File: rtl/ray_result_writer.sv
// ray_result_writer
//   Takes per-pixel results from ray_unit and range-checks them. Each accepted
//   result becomes a linear frame-buffer address, addr = v*DISPLAY_WIDTH + h.
//   Results are queued in a small FIFO and drained into a BRAM write port
//   that the display read side can stall through wr_ready_in. Committed
//   writes are counted, and frame_done_out pulses once per full frame.
//
// Ports
//   clk_in, rst_in          clock, async active-high reset
//   clear_in                sync flush of FIFO, pixel counter and overflow flag
//   result_valid_in         hcount_in / vcount_in / color_in valid this cycle
//   space_out               FIFO not full
//   wr_ready_in             frame-buffer port free this cycle
//   we_out/addr_out/data_out BRAM write port (registered)
//   frame_done_out          1-cycle pulse after the last pixel of a frame
//   overflow_out            sticky: in-range result arrived while FIFO full
//
// Optional build macro RAY_WRITER_STATS_EN adds two saturating 16-bit
// counters: drop_count_out (dropped on full) and oob_count_out (out of range).
module ray_result_writer #(
  parameter int DISPLAY_WIDTH  = 400,
  parameter int DISPLAY_HEIGHT = 300,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 9,
  parameter int FIFO_DEPTH     = 8,
  parameter int ADDR_BITS      = 17
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 clear_in,
  input  logic                 result_valid_in,
  input  logic [H_BITS-1:0]    hcount_in,
  input  logic [V_BITS-1:0]    vcount_in,
  input  logic [3:0]           color_in,
  output logic                 space_out,
  input  logic                 wr_ready_in,
  output logic                 we_out,
  output logic [ADDR_BITS-1:0] addr_out,
  output logic [3:0]           data_out,
  output logic                 frame_done_out,
  output logic                 overflow_out
`ifdef RAY_WRITER_STATS_EN
  ,
  output logic [15:0]          drop_count_out,
  output logic [15:0]          oob_count_out
`endif
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int TOTAL    = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int PIX_BITS = $clog2(TOTAL + 1);

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [3:0]           color;
  } entry_t;

  entry_t               mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0]  count;
  logic [PIX_BITS-1:0]  pix_cnt;

  logic   in_range, full, push, pop, drop_hit;
  entry_t new_entry;

  // Compare at 32 bits so narrow coordinate fields never truncate the limit.
  assign in_range = (32'(hcount_in) < 32'(DISPLAY_WIDTH)) &&
                    (32'(vcount_in) < 32'(DISPLAY_HEIGHT));

  // Full is judged on the registered count; a same-cycle pop frees nothing.
  assign full      = (count == CNT_BITS'(FIFO_DEPTH));
  assign space_out = ~full;

  assign push     = result_valid_in & in_range & ~full & ~clear_in;
  assign pop      = (count != '0) & wr_ready_in & ~clear_in;
  assign drop_hit = result_valid_in & in_range & full;

  assign new_entry.addr  = ADDR_BITS'(vcount_in) * ADDR_BITS'(DISPLAY_WIDTH)
                         + ADDR_BITS'(hcount_in);
  assign new_entry.color = color_in;

  // Storage needs no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

  // Write port registers: addr/data hold between writes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      we_out   <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
    end else begin
      we_out <= pop;
      if (pop) begin
        addr_out <= mem[rd_ptr].addr;
        data_out <= mem[rd_ptr].color;
      end
    end
  end

  // Pixel counter: wraps at a full frame and flags it the following cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pix_cnt        <= '0;
      frame_done_out <= 1'b0;
    end else if (clear_in) begin
      pix_cnt        <= '0;
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= 1'b0;
      if (we_out) begin
        if (pix_cnt == PIX_BITS'(TOTAL - 1)) begin
          pix_cnt        <= '0;
          frame_done_out <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + PIX_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)        overflow_out <= 1'b0;
    else if (clear_in) overflow_out <= 1'b0;
    else if (drop_hit) overflow_out <= 1'b1;
  end

`ifdef RAY_WRITER_STATS_EN
  logic oob_hit;
  assign oob_hit = result_valid_in & ~in_range;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_count_out <= '0;
      oob_count_out  <= '0;
    end else if (clear_in) begin
      drop_count_out <= '0;
      oob_count_out  <= '0;
    end else begin
      if (drop_hit && drop_count_out != 16'hFFFF) drop_count_out <= drop_count_out + 16'd1;
      if (oob_hit  && oob_count_out  != 16'hFFFF) oob_count_out  <= oob_count_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ray_result_writer.sv
// Scoreboard bench for ray_result_writer. u_dut uses the default 400x300
// geometry. u_frm uses an 8x4 frame so that frame wrap can be exercised
// in a short run.
module tb_ray_result_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic        clear, valid, wr_ready;
  logic [8:0]  hc, vc;
  logic [3:0]  col;
  logic        space, we, fdone, ovf;
  logic [16:0] addr;
  logic [3:0]  data;
`ifdef RAY_WRITER_STATS_EN
  logic [15:0] drop_cnt, oob_cnt, f_drop_cnt, f_oob_cnt;
`endif

  // frame instance
  logic        f_valid;
  logic [8:0]  f_hc, f_vc;
  logic        f_space, f_we, f_done, f_ovf;
  logic [4:0]  f_addr;
  logic [3:0]  f_data;

  ray_result_writer u_dut (
    .clk_in(clk), .rst_in(rst), .clear_in(clear),
    .result_valid_in(valid), .hcount_in(hc), .vcount_in(vc), .color_in(col),
    .space_out(space), .wr_ready_in(wr_ready), .we_out(we), .addr_out(addr),
    .data_out(data), .frame_done_out(fdone), .overflow_out(ovf)
`ifdef RAY_WRITER_STATS_EN
    , .drop_count_out(drop_cnt), .oob_count_out(oob_cnt)
`endif
  );

  ray_result_writer #(
    .DISPLAY_WIDTH(8), .DISPLAY_HEIGHT(4), .FIFO_DEPTH(4), .ADDR_BITS(5)
  ) u_frm (
    .clk_in(clk), .rst_in(rst), .clear_in(1'b0),
    .result_valid_in(f_valid), .hcount_in(f_hc), .vcount_in(f_vc), .color_in(4'h3),
    .space_out(f_space), .wr_ready_in(1'b1), .we_out(f_we), .addr_out(f_addr),
    .data_out(f_data), .frame_done_out(f_done), .overflow_out(f_ovf)
`ifdef RAY_WRITER_STATS_EN
    , .drop_count_out(f_drop_cnt), .oob_count_out(f_oob_cnt)
`endif
  );

  typedef struct {
    logic [16:0] addr;
    logic [3:0]  data;
    int          cyc;   // expected we_out cycle, -1 = don't care
  } exp_t;

  exp_t q[$];
  int   wr_cnt = 0;
  int   f_wr_cnt = 0;
  int   f_last_we = 0;
  int   f_pulses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Main monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("write_addr", addr, e.addr);
        chk("write_data", data, e.data);
        if (e.cyc >= 0) chk("write_latency", cyc, e.cyc);
      end
    end
    if (fdone === 1'b1) chk("unexpected_frame_done", 1, 0);
  end

  // Frame monitor: raster stream, so the address is the write index.
  always @(negedge clk) begin
    if (f_we === 1'b1) begin
      chk("frm_addr", f_addr, f_wr_cnt % 32);
      f_wr_cnt++;
      f_last_we = cyc;
    end
    if (f_done === 1'b1) begin
      f_pulses++;
      chk("frm_done_timing", cyc, f_last_we + 1);
      chk("frm_done_count", f_wr_cnt, 32 * f_pulses);
    end
  end

  task automatic send(input int h, input int v, input logic [3:0] c);
    valid = 1'b1; hc = 9'(h); vc = 9'(v); col = c;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) begin @(posedge clk); #1; end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    clear = 0; valid = 0; wr_ready = 0; hc = 0; vc = 0; col = 0;
    f_valid = 0; f_hc = 0; f_vc = 0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_fdone", fdone, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_space", space, 1);
    rst = 0;
    idle(2);

    // single result, latency 2
    wr_ready = 1;
    q.push_back('{17'd60150, 4'hA, cyc + 2});
    send(150, 150, 4'hA);
    idle(1);
    wait_drain();
    idle(5);
    chk("single_writes", wr_cnt, 1);

    // out of range results
    send(400, 0, 4'h1);
    send(0, 300, 4'h2);
    idle(6);
    chk("oob_writes", wr_cnt, 1);
    chk("oob_ovf", ovf, 0);
`ifdef RAY_WRITER_STATS_EN
    chk("oob_count", oob_cnt, 2);
`endif

    // fill while stalled: 8 accepted, 2 dropped
    wr_ready = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) q.push_back('{17'(800 + i), 4'(i), -1});
      send(i, 2, 4'(i));
      if (i == 7) chk("full_space", space, 0);
    end
    idle(3);
    chk("full_space_hold", space, 0);
    chk("full_ovf", ovf, 1);
    chk("stalled_writes", wr_cnt, 1);
`ifdef RAY_WRITER_STATS_EN
    chk("drop_count", drop_cnt, 2);
`endif
    wr_ready = 1;
    wait_drain();
    idle(5);
    chk("drain_writes", wr_cnt, 9);

    // clear with 5 queued and a valid result + ready in the same cycle
    wr_ready = 0;
    for (int i = 0; i < 5; i++) send(10 + i, 5, 4'hC);
    idle(2);
    clear = 1; wr_ready = 1;
    send(20, 5, 4'hD);
    clear = 0; valid = 0;
    chk("clr_we", we, 0);
    chk("clr_space", space, 1);
    chk("clr_ovf", ovf, 0);
`ifdef RAY_WRITER_STATS_EN
    chk("clr_drop", drop_cnt, 0);
    chk("clr_oob", oob_cnt, 0);
`endif
    idle(20);
    chk("clr_writes", wr_cnt, 9);

    // two full frames on the small instance
    for (int fr = 0; fr < 2; fr++) begin
      for (int i = 0; i < 32; i++) begin
        f_valid = 1; f_hc = 9'(i % 8); f_vc = 9'(i / 8);
        @(posedge clk); #1;
      end
      f_valid = 0;
      for (int i = 0; i < 50 && f_pulses != fr + 1; i++) begin @(posedge clk); #1; end
      idle(3);
      chk("frm_pulses", f_pulses, fr + 1);
    end
    chk("frm_total_writes", f_wr_cnt, 64);

    // async reset between edges while a write is on the port
    wr_ready = 1;
    for (int i = 0; i < 3; i++) begin
      q.push_back('{17'(4000 + i), 4'h6, cyc + 2});
      send(i, 10, 4'h6);
    end
    #2 rst = 1; valid = 0;
    #1;
    chk("arst_we", we, 0);
    chk("arst_addr", addr, 0);
    chk("arst_data", data, 0);
    chk("arst_space", space, 1);
    chk("arst_ovf", ovf, 0);
    q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    idle(2);
    chk("arst_writes", wr_cnt, 10);
    q.push_back('{17'd119607, 4'h5, cyc + 2});
    send(7, 299, 4'h5);
    idle(1);
    wait_drain();
    idle(5);
    chk("post_reset_writes", wr_cnt, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
